// File: rtl/arg_arbiter.sv
// rtl/arg_arbiter.sv - round-robin arbiter sharing one multi-cycle angle engine among N_REQ requesters
module arg_arbiter #(
  parameter int NB_IN   = 8,
  parameter int NBF_IN  = 7,
  parameter int NB_OUT  = 8,
  parameter int NBF_OUT = 7,
  parameter int N_REQ   = 4,
  parameter int ENG_LAT = 4,
  localparam int IDW    = $clog2(N_REQ),
  localparam int CW     = $clog2(ENG_LAT + 1)
) (
  input  logic                     clock,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_IN-1:0]   i_num_a,
  input  logic [N_REQ*NB_IN-1:0]   i_num_b,
  output logic [N_REQ-1:0]         o_grant,
  output logic [N_REQ-1:0]         o_valid,
  output logic [IDW-1:0]           o_id,
  output logic [NB_OUT-1:0]        o_arg,
  output logic                     o_busy,
  output logic [NB_IN-1:0]         o_eng_num_a,
  output logic [NB_IN-1:0]         o_eng_num_b,
  output logic                     o_eng_enable,
  input  logic [NB_OUT-1:0]        i_eng_arg
);

  if (N_REQ < 2 || ENG_LAT < 1 || NBF_IN > NB_IN || NBF_OUT > NB_OUT) begin : g_param_chk
    $error("arg_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_q;
  logic [CW-1:0]    cnt;
  logic [NB_IN-1:0] op_a;
  logic [NB_IN-1:0] op_b;

  logic             found;
  logic [IDW-1:0]   win;
  logic [NB_IN-1:0] win_a;
  logic [NB_IN-1:0] win_b;

  // Scan requesters starting at ptr and wrapping; first asserted request wins.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && i_req[j]) begin
        found = 1'b1;
        win   = IDW'(j);
        win_a = i_num_a[j*NB_IN +: NB_IN];
        win_b = i_num_b[j*NB_IN +: NB_IN];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      win_q        <= '0;
      cnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      o_grant      <= '0;
      o_valid      <= '0;
      o_id         <= '0;
      o_arg        <= '0;
      o_eng_enable <= 1'b0;
    end else begin
      o_grant <= '0;
      o_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state        <= BUSY;
            op_a         <= win_a;
            op_b         <= win_b;
            win_q        <= win;
            cnt          <= '0;
            o_grant      <= N_REQ'(1) << win;
            o_eng_enable <= 1'b1;
            ptr          <= (win == IDW'(N_REQ - 1)) ? '0 : win + IDW'(1);
          end
        end
        BUSY: begin
          // Engine result is taken on the edge that closes the last enabled cycle.
          if (cnt == CW'(ENG_LAT - 1)) begin
            state        <= DONE;
            cnt          <= '0;
            o_eng_enable <= 1'b0;
            o_arg        <= i_eng_arg;
            o_id         <= win_q;
            o_valid      <= N_REQ'(1) << win_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_eng_num_a = op_a;
  assign o_eng_num_b = op_b;

endmodule

// File: tb/tb_arg_arbiter.sv
// tb/tb_arg_arbiter.sv - scoreboard bench for arg_arbiter (N_REQ=4, ENG_LAT=4)
module tb_arg_arbiter;

  localparam int N   = 4;
  localparam int NB  = 8;
  localparam int LAT = 4;

  logic          clock = 1'b0;
  logic          i_rst_n;
  logic [N-1:0]  i_req;
  logic [N*NB-1:0] i_num_a, i_num_b;
  logic [N-1:0]  o_grant, o_valid;
  logic [1:0]    o_id;
  logic [7:0]    o_arg;
  logic          o_busy;
  logic [7:0]    o_eng_num_a, o_eng_num_b;
  logic          o_eng_enable;
  logic [7:0]    i_eng_arg;

  typedef struct {
    int         id;
    logic [7:0] arg;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         m_ptr = 0;
  bit         mon_en = 1'b0;
  logic [7:0] last_arg = '0;
  logic [1:0] last_id = '0;

  function automatic logic [7:0] eng_fn(input logic [7:0] a, input logic [7:0] b);
    return a ^ {b[3:0], b[7:4]} ^ 8'h5A;
  endfunction

  assign i_eng_arg = eng_fn(o_eng_num_a, o_eng_num_b);

  arg_arbiter dut (
    .clock        (clock),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_num_a      (i_num_a),
    .i_num_b      (i_num_b),
    .o_grant      (o_grant),
    .o_valid      (o_valid),
    .o_id         (o_id),
    .o_arg        (o_arg),
    .o_busy       (o_busy),
    .o_eng_num_a  (o_eng_num_a),
    .o_eng_num_b  (o_eng_num_b),
    .o_eng_enable (o_eng_enable),
    .i_eng_arg    (i_eng_arg)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      chk("grant_valid_excl", 64'((o_grant != '0) && (o_valid != '0)), 64'd0);
      chk("grant_onehot", 64'($countones(o_grant) <= 1), 64'd1);
      if (o_valid != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(o_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("valid", 64'(o_valid), 64'(4'b1 << e.id));
          chk("id", 64'(o_id), 64'(e.id));
          chk("arg", 64'(o_arg), 64'(e.arg));
          chk("valid_cycle", 64'(cyc), 64'(e.cyc));
          last_arg = e.arg;
          last_id  = 2'(e.id);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 64'(o_grant), 64'd0);
    chk({tag, "_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_id"}, 64'(o_id), 64'd0);
    chk({tag, "_arg"}, 64'(o_arg), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_enable"}, 64'(o_eng_enable), 64'd0);
    chk({tag, "_eng_a"}, 64'(o_eng_num_a), 64'd0);
    chk({tag, "_eng_b"}, 64'(o_eng_num_b), 64'd0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle LAT+2 (next IDLE sample).
  task automatic do_txn(input logic [N-1:0] req, input logic [N*NB-1:0] a, input logic [N*NB-1:0] b,
                        input bit hold, input bit mutate);
    int w;
    exp_t e;
    logic [7:0] ea, eb;
    w  = rr_pick(req, m_ptr);
    ea = a[w*NB +: NB];
    eb = b[w*NB +: NB];
    i_req   = req;
    i_num_a = a;
    i_num_b = b;
    e.id  = w;
    e.arg = eng_fn(ea, eb);
    e.cyc = cyc + LAT + 1;
    sb.push_back(e);
    m_ptr = (w + 1) % N;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clock);
      chk("grant", 64'(o_grant), (c == 1) ? 64'(4'b1 << w) : 64'd0);
      chk("enable", 64'(o_eng_enable), 64'(c <= LAT));
      chk("busy", 64'(o_busy), 64'(c <= LAT + 1));
      chk("eng_a", 64'(o_eng_num_a), 64'(ea));
      chk("eng_b", 64'(o_eng_num_b), 64'(eb));
      if (c == 1 && !hold) i_req = '0;
      if (mutate && c == 1) begin
        i_num_a = {N{8'h7F}};
        i_num_b = {N{8'h81}};
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = '1;
    i_num_a = 32'hDEAD_BEEF;
    i_num_b = 32'h1234_5678;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    i_req   = '0;
    mon_en  = 1'b1;
    @(negedge clock);

    // single request on requester 2
    do_txn(4'b0100, 32'hAA40_BBCC, 32'h5520_6677, 1'b0, 1'b0);
    // operands change right after the grant; engine operands must stay latched
    do_txn(4'b0100, 32'hAA40_BBCC, 32'h5520_6677, 1'b0, 1'b1);
    // bring ptr to 2, then 1010 held: 1000 first, then 0010
    do_txn(4'b0010, 32'h0000_9100, 32'h0000_1900, 1'b0, 1'b0);
    do_txn(4'b1010, 32'h7311_0522, 32'h0C44_3D55, 1'b1, 1'b0);
    do_txn(4'b1010, 32'h7311_0522, 32'h0C44_3D55, 1'b0, 1'b0);

    // reset during BUSY aborts the operation
    i_req   = 4'b1111;
    i_num_a = 32'h0102_0304;
    i_num_b = 32'hF0E0_D0C0;
    @(negedge clock);
    chk("abort_grant", 64'(o_grant), 64'(4'b1 << m_ptr));
    @(negedge clock);
    i_rst_n = 1'b0;
    @(negedge clock);
    chk_all_zero("abort");
    i_rst_n  = 1'b1;
    m_ptr    = 0;
    last_arg = '0;
    last_id  = '0;
    do_txn(4'b1111, 32'h0102_0304, 32'hF0E0_D0C0, 1'b0, 1'b0);

    // move ptr back to 0, then all four held: 0001,0010,0100,1000,0001 every 6 cycles
    do_txn(4'b1000, 32'h8000_0000, 32'h7F00_0000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      do_txn(4'b1111, 32'h1122_3344 + 32'(k), 32'h5566_7788 ^ 32'(k << 8), (k != 4), 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [N-1:0] r;
      r = 4'($urandom_range(1, 15));
      do_txn(r, $urandom, $urandom, 1'b0, 1'b0);
    end

    // idle: nothing moves and the last result holds
    i_req = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("idle_busy", 64'(o_busy), 64'd0);
      chk("idle_enable", 64'(o_eng_enable), 64'd0);
      chk("idle_grant", 64'(o_grant), 64'd0);
      chk("idle_valid", 64'(o_valid), 64'd0);
      chk("idle_arg_hold", 64'(o_arg), 64'(last_arg));
      chk("idle_id_hold", 64'(o_id), 64'(last_id));
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arg_arbiter.md
ARG_ARBITER -- requirements
Module: arg_arbiter

Interface
REQ-001 SHALL have parameter NB_IN, default 8, operand width (signed two's complement).
REQ-002 SHALL have parameter NBF_IN, default 7, operand fractional bits (passed through, unused internally).
REQ-003 SHALL have parameter NB_OUT, default 8, angle width.
REQ-004 SHALL have parameter NBF_OUT, default 7, angle fractional bits (passed through, unused internally).
REQ-005 SHALL have parameter N_REQ, default 4, number of requesters (>=2).
REQ-006 SHALL have parameter ENG_LAT, default 4, angle-engine latency in enabled cycles (>=1).
REQ-007 SHALL use one clock; reset is synchronous and active-low.
REQ-008 clock  input  1  system clock, all logic on rising edge.
REQ-009 i_rst_n  input  1  synchronous active-low reset.
REQ-010 i_req  input  N_REQ  per-requester request, level.
REQ-011 i_num_a  input  N_REQ*NB_IN  packed operand A, requester k at bits [k*NB_IN +: NB_IN].
REQ-012 i_num_b  input  N_REQ*NB_IN  packed operand B, same packing.
REQ-013 o_grant  output  N_REQ  one-hot grant pulse.
REQ-014 o_valid  output  N_REQ  one-hot result-valid pulse.
REQ-015 o_id  output  $clog2(N_REQ)  binary index of requester owning o_arg.
REQ-016 o_arg  output  NB_OUT  registered angle result.
REQ-017 o_busy  output  1  high when state != IDLE.
REQ-018 o_eng_num_a  output  NB_IN  operand A to angle engine.
REQ-019 o_eng_num_b  output  NB_IN  operand B to angle engine.
REQ-020 o_eng_enable  output  1  angle-engine enable.
REQ-021 i_eng_arg  input  NB_OUT  angle-engine result.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-023 IDLE: if any i_req bit high, SHALL select winner by round-robin from pointer ptr upward (mod N_REQ), latch winner operands and index, go to BUSY; else stay IDLE.
REQ-024 o_grant[winner] SHALL be high for exactly the first BUSY cycle; requester may drop i_req or change operands from that cycle.
REQ-025 i_req SHALL be sampled only in IDLE; requests in BUSY/DONE are ignored, not lost while held.
REQ-026 ptr SHALL update to (winner+1) mod N_REQ on the IDLE->BUSY edge.
REQ-027 BUSY: o_eng_enable SHALL be high for exactly ENG_LAT consecutive cycles; cycle counter width $clog2(ENG_LAT+1).
REQ-028 o_eng_num_a/b SHALL drive latched operands, stable for all of BUSY and held after.
REQ-029 On last BUSY cycle edge SHALL capture i_eng_arg into o_arg and winner index into o_id, go to DONE.
REQ-030 DONE: o_valid[o_id] SHALL be high for exactly one cycle; next state IDLE.
REQ-031 Latency: request sampled in cycle t -> o_valid in cycle t+ENG_LAT+1; next sample at t+ENG_LAT+2.
REQ-032 o_arg and o_id SHALL hold their values until the next DONE.
REQ-033 o_grant, o_valid SHALL never have more than one bit set; never both in the same cycle.
REQ-034 No arithmetic on operands or result; widths pass through unchanged.

Reset
REQ-035 i_rst_n low at a rising edge SHALL force state IDLE, ptr 0, counter 0, latched operands 0, and all outputs 0.
REQ-036 Reset in BUSY or DONE SHALL abort the operation; no o_valid for it is ever produced.
REQ-037 First grant after reset SHALL follow priority order starting from requester 0.

Verification (ENG_LAT=4, N_REQ=4; cycle 0 = first IDLE sample)
REQ-038 i_req=0100, a=0x40, b=0x20 at cycle 0 -> o_grant=0100 cycle 1; o_eng_enable cycles 1-4; eng_num=0x40/0x20; o_valid=0100, o_id=2, o_arg=i_eng_arg cycle 5; o_busy low cycle 6.
REQ-039 i_req=1111 held -> grants 0001,0010,0100,1000,0001 at cycles 1,7,13,19,25.
REQ-040 ptr=2, i_req=1010 -> grant 1000 first, then 0010 six cycles later.
REQ-041 Operands changed to 0x7F/0x81 in cycle 2 after grant -> o_eng_num stays 0x40/0x20 through cycle 4.
REQ-042 i_rst_n low in cycle 2 of BUSY -> all outputs 0 cycle 3; no o_valid; with i_req=1111 next grant 0001.
REQ-043 i_req=0000 for 20 cycles -> o_busy, o_eng_enable, o_grant, o_valid stay 0; o_arg holds prior value.
